// File: rtl/step_channel_mux.sv
// step_channel_mux: registered N:1 channel selector with manual select or a rate-divided scan over enabled channels.
module step_channel_mux #(
    parameter int WIDTH    = 3,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3,
    parameter int DIV_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic [CHANNELS-1:0]       en_mask,
    input  logic [DIV_W-1:0]          step_div,
    input  logic                      run,
    output logic [WIDTH-1:0]          y,
    output logic [SEL_W-1:0]          ch,
    output logic                      step,
    output logic                      wrap
);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

    logic [WIDTH-1:0] w_chan [2**SEL_W];
    logic [SEL_W-1:0] w_sel, w_lo, w_hi;
    logic             w_has_hi;
    logic [WIDTH-1:0] r_y;
    logic [SEL_W-1:0] r_ch;
    logic [DIV_W-1:0] r_cnt;
    logic             r_step, r_wrap, r_mode;

    for (genvar k = 0; k < 2**SEL_W; k++) begin : g_chan
        if (k < CHANNELS) begin : g_real
            assign w_chan[k] = din[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign w_chan[k] = '0;
        end
    end

    assign w_sel = (sel_in > LAST) ? LAST : sel_in;

    // Downward walk leaves the lowest enabled index and the lowest one above r_ch.
    always_comb begin
        w_lo     = '0;
        w_hi     = '0;
        w_has_hi = 1'b0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (en_mask[k]) begin
                w_lo = SEL_W'(k);
                if (k > int'(r_ch)) begin
                    w_hi     = SEL_W'(k);
                    w_has_hi = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y    <= '0;
            r_ch   <= '0;
            r_cnt  <= '0;
            r_step <= 1'b0;
            r_wrap <= 1'b0;
            r_mode <= 1'b0;
        end else begin
            r_mode <= mode;
            r_y    <= w_chan[r_ch];
            r_step <= 1'b0;
            r_wrap <= 1'b0;
            if (!mode) begin
                r_cnt  <= '0;
                r_ch   <= w_sel;
                r_step <= (w_sel != r_ch);
            end else if (!r_mode) begin
                r_cnt <= '0;
            end else if (run && |en_mask) begin
                if (r_cnt >= step_div) begin
                    r_cnt  <= '0;
                    r_ch   <= w_has_hi ? w_hi : w_lo;
                    r_step <= 1'b1;
                    r_wrap <= !w_has_hi;
                end else begin
                    r_cnt <= r_cnt + DIV_W'(1);
                end
            end else if (run) begin
                r_cnt <= '0;
            end
        end
    end

    assign y    = r_y;
    assign ch   = r_ch;
    assign step = r_step;
    assign wrap = r_wrap;
endmodule

// File: tb/tb_step_channel_mux.sv
// tb_step_channel_mux: scoreboard against a behavioural model plus table and directed corner sequences.
module tb_step_channel_mux;
    logic        clk = 1'b0;
    logic        rst_n, mode, run;
    logic [23:0] din;
    logic [17:0] din6;
    logic [2:0]  sel_in;
    logic [7:0]  en_mask;
    logic [5:0]  en6;
    logic [15:0] step_div;
    logic [2:0]  y, ch, y6, ch6;
    logic        step, wrap, step6, wrap6;

    step_channel_mux #(.WIDTH(3), .CHANNELS(8), .SEL_W(3), .DIV_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .din(din), .mode(mode), .sel_in(sel_in),
        .en_mask(en_mask), .step_div(step_div), .run(run),
        .y(y), .ch(ch), .step(step), .wrap(wrap)
    );

    step_channel_mux #(.WIDTH(3), .CHANNELS(6), .SEL_W(3), .DIV_W(16)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .din(din6), .mode(mode), .sel_in(sel_in),
        .en_mask(en6), .step_div(step_div), .run(run),
        .y(y6), .ch(ch6), .step(step6), .wrap(wrap6)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] ch;
        logic [2:0] y;
        logic       step;
        logic       wrap;
    } exp_t;

    typedef struct {
        logic [2:0] sel;
        logic [2:0] ch8;
        logic [2:0] y8;
        logic [2:0] ch6;
        logic [2:0] y6;
        logic       step6;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[6];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [2:0]  m_ch = '0, m_y = '0;
    logic        m_step = 1'b0, m_wrap = 1'b0, m_mode = 1'b0;
    logic [15:0] m_cnt = '0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Next state of the design for the coming edge, from the inputs now applied.
    task automatic model_eval();
        int o, nxt, i;
        bit found;
        if (!rst_n) begin
            m_ch = '0; m_y = '0; m_step = 1'b0; m_wrap = 1'b0; m_cnt = '0; m_mode = 1'b0;
        end else begin
            o = int'(m_ch);
            m_y = din[o*3 +: 3];
            m_step = 1'b0;
            m_wrap = 1'b0;
            if (!mode) begin
                m_cnt = '0;
                m_ch = sel_in;
                m_step = (int'(sel_in) != o);
            end else if (!m_mode) begin
                m_cnt = '0;
            end else if (run) begin
                if (en_mask == 8'h00) begin
                    m_cnt = '0;
                end else if (m_cnt >= step_div) begin
                    m_cnt = '0;
                    found = 1'b0;
                    nxt = o;
                    for (int d = 1; d <= 8; d++) begin
                        i = (o + d) % 8;
                        if (!found && en_mask[i]) begin
                            nxt = i;
                            found = 1'b1;
                        end
                    end
                    m_ch = 3'(nxt);
                    m_step = 1'b1;
                    m_wrap = (nxt <= o);
                end else begin
                    m_cnt = m_cnt + 16'd1;
                end
            end
            m_mode = mode;
        end
    endtask

    task automatic tick();
        exp_t e;
        model_eval();
        e = {m_ch, m_y, m_step, m_wrap};
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL sb_underflow: got empty queue expected an entry at %0t", $time);
        end else begin
            e = sb.pop_front();
            check("sb_ch", int'(ch), int'(e.ch));
            check("sb_y", int'(y), int'(e.y));
            check("sb_step", int'(step), int'(e.step));
            check("sb_wrap", int'(wrap), int'(e.wrap));
        end
    endtask

    initial begin
        logic [2:0] seq_ch[4];
        logic       seq_wr[4];
        tbl[0] = '{3'd3, 3'd3, 3'd4, 3'd3, 3'd1, 1'b1};
        tbl[1] = '{3'd7, 3'd7, 3'd0, 3'd5, 3'd5, 1'b1};
        tbl[2] = '{3'd6, 3'd6, 3'd2, 3'd5, 3'd5, 1'b0};
        tbl[3] = '{3'd0, 3'd0, 3'd3, 3'd0, 3'd2, 1'b1};
        tbl[4] = '{3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 1'b1};
        tbl[5] = '{3'd2, 3'd2, 3'd1, 3'd2, 3'd6, 1'b1};
        seq_ch = '{3'd2, 3'd5, 3'd2, 3'd5};
        seq_wr = '{1'b0, 1'b0, 1'b1, 1'b0};

        // channel k data: 3,6,1,4,7,5,2,0 (8-way); 2,4,6,1,3,5 (6-way)
        din      = {3'd0, 3'd2, 3'd5, 3'd7, 3'd4, 3'd1, 3'd6, 3'd3};
        din6     = {3'd5, 3'd3, 3'd1, 3'd6, 3'd4, 3'd2};
        en6      = 6'h3F;
        rst_n    = 1'b0;
        mode     = 1'b0;
        sel_in   = 3'd5;
        en_mask  = 8'hFF;
        step_div = 16'd0;
        run      = 1'b1;

        tick();
        tick();
        check("rst_y", int'(y), 0);
        check("rst_ch", int'(ch), 0);
        rst_n = 1'b1;
        tick();
        check("rel_ch", int'(ch), 5);
        check("rel_step", int'(step), 1);
        tick();
        check("rel_y", int'(y), 5);
        check("rel_step_low", int'(step), 0);

        for (int r = 0; r < 6; r++) begin
            sel_in = tbl[r].sel;
            tick();
            check("tbl_ch8", int'(ch), int'(tbl[r].ch8));
            check("tbl_ch6", int'(ch6), int'(tbl[r].ch6));
            check("tbl_step6", int'(step6), int'(tbl[r].step6));
            check("tbl_wrap6", int'(wrap6), 0);
            tick();
            check("tbl_y8", int'(y), int'(tbl[r].y8));
            check("tbl_y6", int'(y6), int'(tbl[r].y6));
        end

        din[8:6] = 3'd7;
        tick();
        check("din_lat1", int'(y), 7);

        sel_in = 3'd0;
        tick();
        mode = 1'b1;
        run = 1'b1;
        step_div = 16'd3;
        en_mask = 8'hFF;
        tick();
        for (int a = 0; a < 8; a++) begin
            for (int w = 0; w < 3; w++) begin
                tick();
                check("scan_idle_step", int'(step), 0);
            end
            tick();
            check("scan_ch", int'(ch), (a + 1) % 8);
            check("scan_step", int'(step), 1);
            check("scan_wrap", int'(wrap), (a == 7) ? 1 : 0);
        end

        step_div = 16'd0;
        en_mask = 8'b0010_0100;
        for (int s = 0; s < 4; s++) begin
            tick();
            check("sparse_ch", int'(ch), int'(seq_ch[s]));
            check("sparse_wrap", int'(wrap), int'(seq_wr[s]));
        end
        en_mask = 8'h00;
        for (int s = 0; s < 3; s++) begin
            tick();
            check("nomask_ch", int'(ch), 5);
            check("nomask_step", int'(step), 0);
        end

        step_div = 16'd9;
        en_mask = 8'hFF;
        repeat (4) tick();
        run = 1'b0;
        for (int s = 0; s < 10; s++) begin
            tick();
            check("pause_ch", int'(ch), 5);
            check("pause_step", int'(step), 0);
        end
        run = 1'b1;
        step_div = 16'd2;
        tick();
        check("shrink_ch", int'(ch), 6);
        check("shrink_step", int'(step), 1);

        rst_n = 1'b0;
        tick();
        check("midrst_ch", int'(ch), 0);
        check("midrst_y", int'(y), 0);
        check("midrst_step", int'(step), 0);
        rst_n = 1'b1;
        step_div = 16'd0;
        en_mask = 8'b0100_0000;
        tick();
        tick();
        check("solo_ch", int'(ch), 6);
        tick();
        check("solo_hold_ch", int'(ch), 6);
        check("solo_wrap", int'(wrap), 1);
        mode = 1'b0;
        sel_in = 3'd3;
        tick();
        check("m10_ch", int'(ch), 3);
        check("m10_step", int'(step), 1);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            rst_n = ($urandom_range(0, 59) != 0);
            sel_in = 3'($urandom);
            en_mask = ($urandom_range(0, 3) == 0) ? 8'($urandom & $urandom) : 8'($urandom);
            run = ($urandom_range(0, 7) != 0);
            step_div = 16'($urandom_range(0, 4));
            din = 24'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/step_channel_mux.md
Name: step_channel_mux

Overview:
- Parametrised, registered N:1 channel selector for the synth datapath; generalises the 8-way 3-bit selector.
- Two modes:
  - Manual: an external select picks the channel.
  - Scan: an internal step sequencer walks the enabled channels at a programmable rate.
- Feeds note/voice data to downstream voice logic.
- Emits step and wrap strobes for sequencing and LED logic.

Parameters:
- WIDTH, 3: bits per channel.
- CHANNELS, 8: number of input channels, 2..64.
- SEL_W, 3: select/index width; must be >= clog2(CHANNELS).
- DIV_W, 16: width of the step-rate divider.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset.
- din  in  CHANNELS*WIDTH  flattened channel data; channel k occupies [k*WIDTH +: WIDTH].
- mode  in  1  0 = manual select, 1 = scan.
- sel_in  in  SEL_W  manual channel select.
- en_mask  in  CHANNELS  per-channel enable, used in scan mode only.
- step_div  in  DIV_W  scan period minus one, in clk cycles.
- run  in  1  scan enable; 0 pauses the sequencer.
- y  out  WIDTH  registered selected data.
- ch  out  SEL_W  current channel index, registered.
- step  out  1  one-cycle pulse on each scan advance or manual channel change.
- wrap  out  1  one-cycle pulse when a scan advance wraps.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset rst_n is synchronous and active-low.
  - While rst_n=0 at a rising edge: y=0, ch=0, step=0, wrap=0, divider count=0.
  - Reset mid-scan is honoured at the next edge, with no partial advance.
- Data path:
  - y <= din[ch] every cycle, where ch is the registered index.
  - Latency: 1 cycle from a din change; 2 cycles from a select or advance, because ch updates first and y follows.
- Manual mode (mode=0):
  - ch <= sel_in when sel_in < CHANNELS, else ch <= CHANNELS-1. Out-of-range selects the last channel.
  - en_mask, run and step_div are ignored.
  - Divider count held at 0.
  - step=1 for one cycle when ch changes value; wrap=0 always.
- Scan mode (mode=1):
  - Divider count cnt increments each cycle while run=1.
  - When run=1 and cnt >= step_div, an advance occurs: cnt <= 0.
  - The `>=` compare makes a lowered step_div take effect immediately.
  - step_div=0 advances every cycle.
  - run=0: cnt and ch hold; no strobes.
- Advance rule:
  - ch <= lowest enabled index strictly greater than ch.
  - If none exists, ch <= lowest enabled index and wrap=1.
  - step=1 on every advance.
  - If only the current channel is enabled, ch is unchanged and step=1, wrap=1.
  - en_mask=0: no advance, no strobes, ch holds, cnt held at 0.
  - Enable bits at or above CHANNELS do not exist; mask width equals CHANNELS.
- Current channel disabled mid-scan: ch holds until the next advance, then moves per the advance rule.
- Mode switches:
  - 0->1: cnt cleared to 0; scanning starts from the current ch. The first advance occurs after step_div+1 cycles.
  - 1->0: ch <= resolved sel_in on the next edge; step pulses if the value changed.
- step and wrap are registered, asserted in the same cycle ch takes its new value, and never high for two consecutive cycles unless advances are consecutive (step_div=0).
- Priority within a cycle: reset > mode change > advance.

Test Plan:
- Reset, manual select:
  - rst_n=0 for 2 cycles, then mode=0, sel_in=5, din channel5=3'b101 -> y=0 during reset.
  - ch=5 one edge after release, with step=1 for that cycle.
  - y=3'b101 one edge later.
- Manual out-of-range (CHANNELS=6, SEL_W=3): sel_in=7 -> ch=5; y=channel5 data.
- Scan rate and wrap:
  - mode=1, run=1, step_div=3, en_mask=8'hFF -> ch advances every 4 cycles: 0,1,...,7,0.
  - wrap=1 only on the 7->0 advance.
  - step=1 on each advance.
- Sparse mask:
  - en_mask=8'b0010_0100, step_div=0, ch=0 -> ch sequence 2,5,2,5 on consecutive cycles.
  - wrap on each 5->2.
  - en_mask=0 -> ch frozen, no strobes.
- Pause and divider shrink:
  - step_div=9; run=0 at cnt=4 for 10 cycles -> ch holds.
  - run=1 and step_div=2 set simultaneously -> advance on the next edge (cnt 4>=2).
- Mid-scan reset and mode switch:
  - Assert rst_n=0 one cycle at ch=6 -> ch=0, y=0, no strobe.
  - Switch mode 1->0 with sel_in=3 -> ch=3 the next edge, step=1.
